// File: rtl/inst_fetch_pkg.sv
// Shared CPU fetch definitions: default instruction/reset constants and fetch FSM states.
package inst_fetch_pkg;

    localparam logic [31:0] DEFAULT_NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface inst_fetch_if;

    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemGnt,
        input  imemRvalid,
        input  imemRdata
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemGnt,
        output imemRvalid,
        output imemRdata
    );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem read, IF/ID register, stall buffering and flush kill.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INST   = DEFAULT_NOP_INST,
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [31:0]         pcIn,
    input  logic                stallIn,
    input  logic                flushIn,
    output logic                pcStall,
    inst_fetch_if.master        imem,
    output logic [31:0]         instOut,
    output logic [31:0]         instPcOut,
    output logic                instValid
);

    fetch_state_e state_q, state_d;
    logic         kill_q, kill_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic         deliver;
    logic [31:0]  deliver_data;

    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        addr_d       = addr_q;
        buf_d        = buf_q;
        deliver      = 1'b0;
        deliver_data = buf_q;

        case (state_q)
            IDLE: begin
                if (en && !flushIn) begin
                    addr_d  = pcIn;
                    state_d = REQ;
                end
            end
            // The request stays up until granted; a flush only marks the response for discard.
            REQ: begin
                if (flushIn) kill_d = 1'b1;
                if (imem.imemGnt) state_d = WAIT;
            end
            WAIT: begin
                if (imem.imemRvalid) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    if (!kill_q && !flushIn) begin
                        if (stallIn) begin
                            buf_d   = imem.imemRdata;
                            state_d = HOLD;
                        end else begin
                            deliver      = 1'b1;
                            deliver_data = imem.imemRdata;
                        end
                    end
                end else if (flushIn) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (flushIn) begin
                    state_d = IDLE;
                end else if (!stallIn) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush beats stall; otherwise an unstalled, non-delivering cycle presents a NOP.
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flushIn) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (deliver) begin
            inst_d  = deliver_data;
            pc_d    = addr_q;
            valid_d = 1'b1;
        end else if (!stallIn) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            addr_q  <= RESET_ADDR;
            inst_q  <= NOP_INST;
            pc_q    <= RESET_ADDR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign imem.imemReq  = (state_q == REQ);
    assign imem.imemAddr = addr_q;
    assign pcStall       = rst | ~deliver;
    assign instOut       = inst_q;
    assign instPcOut     = pc_q;
    assign instValid     = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a scripted imem model pushes expected instructions, a monitor pops them on instValid.
module tb_inst_fetch;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RADDR = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] pcIn = 32'h0;
    logic        stallIn = 1'b0;
    logic        flushIn = 1'b0;
    logic        pcStall;
    logic [31:0] instOut;
    logic [31:0] instPcOut;
    logic        instValid;

    inst_fetch_if imem_bus ();

    inst_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pcIn      (pcIn),
        .stallIn   (stallIn),
        .flushIn   (flushIn),
        .pcStall   (pcStall),
        .imem      (imem_bus),
        .instOut   (instOut),
        .instPcOut (instPcOut),
        .instValid (instValid)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_push = 0;
    int          n_pop = 0;
    logic [63:0] sb_q[$];
    logic        prev_v = 1'b0;
    logic        prev_s = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Each fresh instValid rise (not a stall-held repeat) consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && instValid && !(prev_v && prev_s)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_valid", 32'(instValid), 32'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                n_pop++;
                chk("sb_inst", instOut, e[63:32]);
                chk("sb_pc", instPcOut, e[31:0]);
            end
        end
        prev_v <= instValid;
        prev_s <= stallIn;
    end

    task automatic run_fetch(input logic [31:0] pc, input logic [31:0] data, input int gdelay,
                             input int sdelay, input int hold, input bit flush_out);
        en = 1'b1; pcIn = pc; stallIn = 1'b0;
        cyc();
        en = 1'b0;
        for (int i = 0; i < gdelay; i++) begin
            #1;
            chk("req_wait_req", 32'(imem_bus.imemReq), 32'd1);
            chk("req_wait_addr", imem_bus.imemAddr, pc);
            chk("req_wait_pcstall", 32'(pcStall), 32'd1);
            chk("req_wait_valid", 32'(instValid), 32'd0);
            cyc();
        end
        imem_bus.imemGnt = 1'b1;
        #1;
        chk("gnt_req", 32'(imem_bus.imemReq), 32'd1);
        chk("gnt_addr", imem_bus.imemAddr, pc);
        cyc();
        imem_bus.imemGnt = 1'b0;
        imem_bus.imemRvalid = 1'b1; imem_bus.imemRdata = data;
        stallIn = (sdelay > 0);
        sb_q.push_back({data, pc}); n_push++;
        #1;
        chk("rvalid_pcstall", 32'(pcStall), (sdelay > 0) ? 32'd1 : 32'd0);
        cyc();
        imem_bus.imemRvalid = 1'b0;
        if (sdelay > 0) begin
            for (int i = 0; i < sdelay; i++) begin
                #1;
                chk("hold_pcstall", 32'(pcStall), 32'd1);
                chk("hold_novalid", 32'(instValid), 32'd0);
                cyc();
            end
            stallIn = 1'b0;
            #1;
            chk("release_pcstall", 32'(pcStall), 32'd0);
            cyc();
        end
        stallIn = (hold > 0) || flush_out;
        flushIn = flush_out;
        #1;
        chk("deliver_valid", 32'(instValid), 32'd1);
        chk("deliver_pcstall", 32'(pcStall), 32'd1);
        if (flush_out) begin
            cyc();
            flushIn = 1'b0; stallIn = 1'b0;
            #1;
            chk("flush_over_stall_valid", 32'(instValid), 32'd0);
            chk("flush_over_stall_inst", instOut, NOP);
        end else begin
            for (int i = 0; i < hold; i++) begin
                cyc();
                #1;
                chk("out_hold_valid", 32'(instValid), 32'd1);
                chk("out_hold_inst", instOut, data);
                chk("out_hold_pc", instPcOut, pc);
            end
            stallIn = 1'b0;
            cyc();
            #1;
            chk("pulse_end_valid", 32'(instValid), 32'd0);
            chk("pulse_end_inst", instOut, NOP);
        end
    endtask

    initial begin
        imem_bus.imemGnt = 1'b0;
        imem_bus.imemRvalid = 1'b0;
        imem_bus.imemRdata = 32'h0;

        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_req", 32'(imem_bus.imemReq), 32'd0);
        chk("rst_addr", imem_bus.imemAddr, RADDR);
        chk("rst_inst", instOut, NOP);
        chk("rst_pc", instPcOut, RADDR);
        chk("rst_valid", 32'(instValid), 32'd0);
        chk("rst_pcstall", 32'(pcStall), 32'd1);

        // Minimum-latency fetch, then long grant delay, then stall on arrival.
        run_fetch(32'h0040_0000, 32'h0050_0093, 0, 0, 0, 1'b0);
        run_fetch(32'h0040_0004, 32'h0010_0193, 4, 0, 0, 1'b0);
        run_fetch(32'h0040_0008, 32'h00A0_0113, 0, 3, 0, 1'b0);
        run_fetch(32'h0040_000C, 32'hDEAD_BEEF, 1, 0, 2, 1'b0);
        run_fetch(32'h0040_0010, 32'h1234_5678, 0, 0, 0, 1'b1);

        // Flush during WAIT discards the late response.
        en = 1'b1; pcIn = 32'h0040_0100;
        cyc();
        en = 1'b0; imem_bus.imemGnt = 1'b1;
        cyc();
        imem_bus.imemGnt = 1'b0; flushIn = 1'b1; pcIn = 32'h0040_0200;
        #1;
        chk("flw_pcstall", 32'(pcStall), 32'd1);
        cyc();
        flushIn = 1'b0;
        imem_bus.imemRvalid = 1'b1; imem_bus.imemRdata = 32'hBAD0_0001;
        #1;
        chk("flw_rv_pcstall", 32'(pcStall), 32'd1);
        cyc();
        imem_bus.imemRvalid = 1'b0;
        #1;
        chk("flw_valid", 32'(instValid), 32'd0);
        chk("flw_inst", instOut, NOP);
        chk("flw_req", 32'(imem_bus.imemReq), 32'd0);
        run_fetch(32'h0040_0200, 32'h0020_0213, 0, 0, 0, 1'b0);

        // Flush during REQ: request held until grant, response discarded.
        en = 1'b1; pcIn = 32'h0040_0300;
        cyc();
        en = 1'b0; flushIn = 1'b1; pcIn = 32'h0040_0400;
        #1;
        chk("flr_req", 32'(imem_bus.imemReq), 32'd1);
        cyc();
        flushIn = 1'b0;
        #1;
        chk("flr_req_kept", 32'(imem_bus.imemReq), 32'd1);
        chk("flr_addr_kept", imem_bus.imemAddr, 32'h0040_0300);
        imem_bus.imemGnt = 1'b1;
        cyc();
        imem_bus.imemGnt = 1'b0;
        cyc();
        imem_bus.imemRvalid = 1'b1; imem_bus.imemRdata = 32'hBAD0_0002;
        #1;
        chk("flr_rv_pcstall", 32'(pcStall), 32'd1);
        cyc();
        imem_bus.imemRvalid = 1'b0;
        #1;
        chk("flr_valid", 32'(instValid), 32'd0);
        chk("flr_req_idle", 32'(imem_bus.imemReq), 32'd0);

        // Flush during HOLD drops the buffered word.
        en = 1'b1; pcIn = 32'h0040_0500;
        cyc();
        en = 1'b0; imem_bus.imemGnt = 1'b1;
        cyc();
        imem_bus.imemGnt = 1'b0;
        imem_bus.imemRvalid = 1'b1; imem_bus.imemRdata = 32'hBAD0_0003; stallIn = 1'b1;
        cyc();
        imem_bus.imemRvalid = 1'b0;
        cyc();
        flushIn = 1'b1;
        #1;
        chk("flh_pcstall", 32'(pcStall), 32'd1);
        cyc();
        flushIn = 1'b0; stallIn = 1'b0;
        #1;
        chk("flh_valid", 32'(instValid), 32'd0);
        chk("flh_inst", instOut, NOP);
        cyc();
        #1;
        chk("flh_no_late_valid", 32'(instValid), 32'd0);
        chk("flh_pcstall_idle", 32'(pcStall), 32'd1);

        // Reset during WAIT, response arrives afterwards in IDLE.
        en = 1'b1; pcIn = 32'h0040_0600;
        cyc();
        en = 1'b0; imem_bus.imemGnt = 1'b1;
        cyc();
        imem_bus.imemGnt = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        imem_bus.imemRvalid = 1'b1; imem_bus.imemRdata = 32'hBAD0_0004;
        #1;
        chk("rw_rv_pcstall", 32'(pcStall), 32'd1);
        cyc();
        imem_bus.imemRvalid = 1'b0;
        #1;
        chk("rw_req", 32'(imem_bus.imemReq), 32'd0);
        chk("rw_addr", imem_bus.imemAddr, RADDR);
        chk("rw_inst", instOut, NOP);
        chk("rw_pc", instPcOut, RADDR);
        chk("rw_valid", 32'(instValid), 32'd0);

        // Disabled CPU never requests.
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            chk("idle_req", 32'(imem_bus.imemReq), 32'd0);
            chk("idle_pcstall", 32'(pcStall), 32'd1);
        end

        cyc();
        chk("sb_left", 32'(sb_q.size()), 32'd0);
        chk("sb_count", 32'(n_pop), 32'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
